// File: rtl/dmem_pkg.sv
// Shared types and constants for the MEM-stage data memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [6:0] OPC_LD = 7'b0000011;
  localparam logic [6:0] OPC_SD = 7'b0100011;

  localparam int DEFAULT_DEPTH   = 1024;
  localparam int DEFAULT_LATENCY = 2;

endpackage

// File: rtl/dmem_array.sv
// Word-addressed 32-bit storage: one synchronous write port, one combinational read port.
// Contents power up as word i = i and are never touched by reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  typedef logic [DEPTH-1:0][31:0] mem_t;

  function automatic mem_t init_words();
    mem_t m;
    for (int i = 0; i < DEPTH; i++) m[i] = 32'(i);
    return m;
  endfunction

  mem_t mem = init_words();

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data memory responder with fixed access latency.
// Requests are captured in IDLE, committed on the edge entering RESP, and held until consumed.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int LATENCY = DEFAULT_LATENCY,
  parameter int DEPTH   = DEFAULT_DEPTH
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  output logic [15:0] ld_count,
  output logic [15:0] sd_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  state_t      state, state_nxt;
  logic [3:0]  cnt_p0;
  logic [6:0]  op_p0;
  logic [63:0] addr_p0;
  logic [31:0] wdata_p0;
  logic [31:0] rdata_p1;
  logic        err_p1;

  logic        accept, commit;
  logic [6:0]  cur_op;
  logic [63:0] cur_addr;
  logic [31:0] cur_wdata;
  logic        cur_err;
  logic        cur_store;
  logic        arr_we;
  logic [31:0] arr_rdata;
  logic        unused_wdata_hi;

  assign unused_wdata_hi = ^req_wdata[63:32];

  assign req_ready = (state == ST_IDLE);
  assign accept    = req_ready && req_valid;

  // With LATENCY=1 the commit happens on the acceptance edge, so the live request is used.
  assign cur_op    = (state == ST_IDLE) ? (req_we ? OPC_SD : OPC_LD) : op_p0;
  assign cur_addr  = (state == ST_IDLE) ? req_addr : addr_p0;
  assign cur_wdata = (state == ST_IDLE) ? req_wdata[31:0] : wdata_p0;
  assign cur_err   = (cur_addr[1:0] != 2'b00) || (cur_addr[63:2] > 62'(DEPTH - 1));
  assign cur_store = (cur_op == OPC_SD);
  assign arr_we    = commit && cur_store && !cur_err && reset_n;

  always_comb begin
    state_nxt = state;
    commit    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_nxt = ST_RESP;
            commit    = 1'b1;
          end else begin
            state_nxt = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_p0 == 4'd0) begin
          state_nxt = ST_RESP;
          commit    = 1'b1;
        end
      end
      ST_RESP: begin
        if (resp_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Stage p0: request capture and latency countdown
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      cnt_p0   <= 4'd0;
      ld_count <= 16'd0;
      sd_count <= 16'd0;
    end else begin
      state <= state_nxt;
      if (accept) cnt_p0 <= 4'(LATENCY - 1);
      else if (state == ST_WAIT && cnt_p0 != 4'd0) cnt_p0 <= cnt_p0 - 4'd1;
      if (commit && !cur_err) begin
        if (cur_store) sd_count <= sat_inc(sd_count);
        else           ld_count <= sat_inc(ld_count);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (accept) begin
      op_p0    <= req_we ? OPC_SD : OPC_LD;
      addr_p0  <= req_addr;
      wdata_p0 <= req_wdata[31:0];
    end
    if (commit) begin
      rdata_p1 <= (cur_store || cur_err) ? 32'd0 : arr_rdata;
      err_p1   <= cur_err;
    end
  end

  // Stage p1: response held until consumed
  assign resp_valid = (state == ST_RESP);
  assign resp_rdata = resp_valid ? {32'd0, rdata_p1} : 64'd0;
  assign resp_err   = resp_valid && err_p1;

  dmem_array #(.DEPTH(DEPTH)) u_array (
    .clock (clock),
    .we    (arr_we),
    .waddr (cur_addr[AW+1:2]),
    .wdata (cur_wdata),
    .raddr (cur_addr[AW+1:2]),
    .rdata (arr_rdata)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: LATENCY=2 instance for function/reset, LATENCY=1 for throughput.
module tb_dmem_responder;

  localparam int LAT   = 2;
  localparam int DEPTH = 1024;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;

  logic        req_valid = 1'b0, req_we = 1'b0, resp_ready = 1'b0;
  logic [63:0] req_addr = 64'd0, req_wdata = 64'd0;
  logic        req_ready, resp_valid, resp_err;
  logic [63:0] resp_rdata;
  logic [15:0] ld_count, sd_count;

  logic        req_valid1 = 1'b0;
  logic [63:0] req_addr1 = 64'd0;
  logic        req_ready1, resp_valid1, resp_err1;
  logic [63:0] resp_rdata1;
  logic [15:0] ld_count1, sd_count1;

  int n_checks = 0;
  int n_fail   = 0;

  exp_t        sb[$];
  exp_t        sb1[$];
  logic [31:0] model_mem [DEPTH];
  int          exp_ld = 0, exp_sd = 0;

  always #5 clock = ~clock;

  dmem_responder #(.LATENCY(LAT), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .ld_count(ld_count), .sd_count(sd_count)
  );

  dmem_responder #(.LATENCY(1), .DEPTH(DEPTH)) dut1 (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid1), .req_ready(req_ready1), .req_we(1'b0),
    .req_addr(req_addr1), .req_wdata(64'd0),
    .resp_valid(resp_valid1), .resp_ready(1'b1),
    .resp_rdata(resp_rdata1), .resp_err(resp_err1),
    .ld_count(ld_count1), .sd_count(sd_count1)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic addr_err(input logic [63:0] a);
    return (a[1:0] != 2'b00) || ((a >> 2) >= 64'(DEPTH));
  endfunction

  task automatic check_counts(input string tag);
    check({tag, "_ld"}, 64'(ld_count), 64'(exp_ld));
    check({tag, "_sd"}, 64'(sd_count), 64'(exp_sd));
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
  task automatic issue(input string tag, input logic we, input logic [63:0] addr,
                       input logic [63:0] wdata, input int hold);
    exp_t e;
    int   lat;
    e.err   = addr_err(addr);
    e.rdata = (we || e.err) ? 64'd0 : {32'd0, model_mem[addr >> 2]};
    sb.push_back(e);
    if (!e.err) begin
      if (we) begin model_mem[addr >> 2] = wdata[31:0]; exp_sd++; end
      else exp_ld++;
    end
    check({tag, "_ready"}, 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    @(negedge clock);
    req_valid = 1'b0;
    lat = 0;
    while (!resp_valid && lat < 40) begin
      @(negedge clock);
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'(LAT));
    for (int i = 0; i < hold; i++) begin
      check({tag, "_hold_valid"}, 64'(resp_valid), 64'd1);
      check({tag, "_hold_rdata"}, resp_rdata, sb[0].rdata);
      check({tag, "_hold_ready"}, 64'(req_ready), 64'd0);
      req_valid = 1'b1; req_we = 1'b0; req_addr = 64'h4;
      @(negedge clock);
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    if (sb.size() == 0) begin
      check({tag, "_sb_nonempty"}, 64'd0, 64'd1);
    end else begin
      e = sb.pop_front();
      check({tag, "_valid"}, 64'(resp_valid), 64'd1);
      check({tag, "_rdata"}, resp_rdata, e.rdata);
      check({tag, "_err"}, 64'(resp_err), 64'(e.err));
    end
    @(negedge clock);
    resp_ready = 1'b0;
    check({tag, "_done_valid"}, 64'(resp_valid), 64'd0);
    check({tag, "_done_ready"}, 64'(req_ready), 64'd1);
    if (hold > 0) begin
      @(negedge clock);
      check({tag, "_not_queued"}, 64'(resp_valid), 64'd0);
    end
    check_counts(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n_acc;
    logic acc;
    exp_t e;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'(i);

    repeat (2) @(negedge clock);
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_resp_rdata", resp_rdata, 64'd0);
    check("rst_resp_err", 64'(resp_err), 64'd0);
    check_counts("rst");
    reset_n = 1'b1;
    @(negedge clock);

    issue("ld8", 1'b0, 64'h8, 64'd0, 0);
    issue("sd10", 1'b1, 64'h10, 64'hDEADBEEF_000000F0, 0);
    issue("ld10", 1'b0, 64'h10, 64'd0, 0);
    issue("ldhold", 1'b0, 64'hC, 64'd0, 5);
    issue("sd_mis", 1'b1, 64'h6, 64'h5555_5555, 0);
    issue("sd_oor", 1'b1, 64'(4 * DEPTH), 64'h6666_6666, 0);
    issue("ld4", 1'b0, 64'h4, 64'd0, 0);
    issue("ld_last", 1'b0, 64'(4 * DEPTH - 4), 64'd0, 0);
    issue("ld_oor", 1'b0, 64'(4 * DEPTH), 64'd0, 0);
    issue("sd_w1", 1'b1, 64'h4, 64'hFFFF_FFFF_A5A5_0001, 0);
    issue("ld_w1", 1'b0, 64'h4, 64'd0, 0);

    // Reset while a store to word 8 sits in WAIT.
    req_valid = 1'b1; req_we = 1'b1; req_addr = 64'h20; req_wdata = 64'h1234_5678;
    @(negedge clock);
    req_valid = 1'b0;
    check("rstw_in_wait", 64'(req_ready), 64'd0);
    reset_n = 1'b0;
    #1;
    check("rstw_ready", 64'(req_ready), 64'd1);
    check("rstw_valid", 64'(resp_valid), 64'd0);
    #1;
    reset_n = 1'b1;
    exp_ld = 0; exp_sd = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("rstw_no_resp", 64'(resp_valid), 64'd0);
    end
    check_counts("rstw");
    issue("ld20", 1'b0, 64'h20, 64'd0, 0);

    // LATENCY=1 back-to-back loads, response consumed immediately.
    n_acc = 0;
    req_addr1 = 64'h8;
    req_valid1 = 1'b1;
    for (int c = 0; c < 12; c++) begin
      acc = req_ready1;
      check("l1_ready_pattern", 64'(req_ready1), 64'(c % 2 == 0));
      if (acc) begin
        e.err = 1'b0;
        e.rdata = {32'd0, model_mem[req_addr1 >> 2]};
        sb1.push_back(e);
      end
      @(negedge clock);
      if (acc) begin
        check("l1_resp_valid", 64'(resp_valid1), 64'd1);
        if (sb1.size() != 0) begin
          e = sb1.pop_front();
          check("l1_rdata", resp_rdata1, e.rdata);
          check("l1_err", 64'(resp_err1), 64'(e.err));
        end
        n_acc++;
        req_addr1 = 64'(4 * (n_acc * 3 + 2));
      end else begin
        check("l1_gap", 64'(resp_valid1), 64'd0);
      end
    end
    req_valid1 = 1'b0;
    check("l1_accepts", 64'(n_acc), 64'd6);
    check("l1_ld_count", 64'(ld_count1), 64'd6);
    check("sb_empty", 64'(sb.size() + sb1.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter LATENCY, default 2: cycles from request acceptance to resp_valid; legal range 1..15.
REQ-002 Parameter DEPTH, default 1024: number of 32-bit data words.
REQ-003 clock  in  1: single clock; all state updates occur on posedge clock.
REQ-004 reset_n  in  1: asynchronous, active-low reset.
REQ-005 req_valid  in  1: MEM-stage access request present.
REQ-006 req_ready  out  1: responder can accept a request this cycle.
REQ-007 req_we  in  1: 1 = store (SD), 0 = load (LD).
REQ-008 req_addr  in  64: byte address, equal to EXMEMALUOut.
REQ-009 req_wdata  in  64: store data, equal to EXMEMB; only bits 31:0 are stored.
REQ-010 resp_valid  out  1: response available.
REQ-011 resp_ready  in  1: pipeline consumes the response.
REQ-012 resp_rdata  out  64: load data, zero-extended 32-bit word; 0 for stores and errors.
REQ-013 resp_err  out  1: the request was misaligned or out of range.
REQ-014 ld_count, sd_count  out  16 each: saturating counts of completed non-error loads and stores.

Function
REQ-015 The FSM SHALL have three states: IDLE, WAIT and RESP. req_ready SHALL be 1 only in IDLE.
REQ-016 IDLE SHALL go to WAIT on req_valid&&req_ready; the request fields SHALL be captured on that edge.
REQ-017 In WAIT, a down-counter SHALL be loaded with LATENCY-1 at acceptance and decrement each cycle; when the counter reaches 0, the FSM SHALL go to RESP. With LATENCY=1, WAIT SHALL last 0 cycles (transition IDLE->RESP directly).
REQ-018 resp_valid SHALL rise exactly LATENCY cycles after the acceptance edge and SHALL stay high with stable resp_rdata/resp_err until resp_valid&&resp_ready.
REQ-019 RESP SHALL go to IDLE on resp_ready; a new request SHALL NOT be accepted in the same cycle (at most one outstanding request).
REQ-020 Word index SHALL be req_addr>>2.
REQ-021 resp_err SHALL be 1 if req_addr[1:0]!=0 or index>DEPTH-1.
REQ-022 Loads and stores SHALL be committed on the edge entering RESP; an errored store SHALL NOT write memory.
REQ-023 The load value SHALL be the memory word at commit time.
REQ-024 A store SHALL be visible to every request accepted after its response is consumed.
REQ-025 Counters SHALL increment at commit and hold at 16'hFFFF.
REQ-026 req_valid seen outside IDLE SHALL be ignored and SHALL NOT be queued.

Reset
REQ-027 On reset_n low, the block SHALL immediately enter IDLE; outputs SHALL be req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, counters=0.
REQ-028 A reset during WAIT SHALL discard the pending request with no memory write; a reset during RESP SHALL drop the response.
REQ-029 Memory contents SHALL NOT be affected by reset. The simulation initial value SHALL be word i = i.

Structure
REQ-030 Package dmem_pkg SHALL hold the state enum, the LD/SD opcode constants (7'b0000011, 7'b0100011) and the default DEPTH/LATENCY values.
REQ-031 The storage array SHALL be the sub-module dmem_array: one synchronous write port and one read port.

Verification
REQ-032 LATENCY=2, load from addr 0x8 after reset -> resp_valid 2 cycles after acceptance, resp_rdata=2, resp_err=0, ld_count=1.
REQ-033 Store wdata=0xDEADBEEF_000000F0 to addr 0x10, then load 0x10 -> resp_rdata=0x000000F0, sd_count=1.
REQ-034 resp_ready held low 5 cycles in RESP -> resp_valid/rdata stable for all 5 cycles, req_ready=0, and a second req_valid is ignored.
REQ-035 Store to addr 0x6 (misaligned) and to addr 4*DEPTH (out of range) -> resp_err=1 for both, memory unchanged, counters unchanged.
REQ-036 reset_n pulsed low mid-WAIT of a store to 0x20 -> resp_valid never rises, word 8 still reads 8, counters 0.
REQ-037 LATENCY=1 back-to-back loads with resp_ready tied 1 -> one request accepted every 2 cycles, each response 1 cycle after its acceptance.
